// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: shares the single system-bus master port between the
// instruction-fetch cache (client 0) and the data cache (client 1).
// One complete transaction at a time: the request is registered onto the bus,
// held until reqack, then BEATS response beats go back to the owner only.
// Build option: define SYSBUS_ARB_ROUND_ROBIN_EN for round-robin arbitration
// on simultaneous requests. Without it, the data cache always has priority.
module sysbus_arbiter #(
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      c0_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] c0_req,
    input  logic [BUS_TAG_WIDTH-1:0]  c0_reqtag,
    output logic                      c0_reqack,
    output logic                      c0_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] c0_resp,
    output logic [BUS_TAG_WIDTH-1:0]  c0_resptag,
    input  logic                      c0_respack,
    input  logic                      c1_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] c1_req,
    input  logic [BUS_TAG_WIDTH-1:0]  c1_reqtag,
    output logic                      c1_reqack,
    output logic                      c1_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] c1_resp,
    output logic [BUS_TAG_WIDTH-1:0]  c1_resptag,
    input  logic                      c1_respack,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,
    output logic                      owner,
    output logic                      busy
);

    localparam int CW = $clog2(BEATS + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   beat_cnt;
    logic            winner;
    logic            in_resp;
    logic            owner_respack;
    logic            beat;
    logic            last_beat;

    // Pick the client to grant when leaving IDLE. The owner register doubles
    // as "last owner": it only changes on IDLE->REQ and resets to 0, so the
    // data cache naturally wins the first simultaneous round after reset.
    always_comb begin
`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
        if (c0_reqcyc && c1_reqcyc)
            winner = ~owner;
        else
            winner = c1_reqcyc;
`else
        winner = c1_reqcyc;
`endif
    end

    assign in_resp       = (state == WAIT) || (state == RESP);
    assign owner_respack = owner ? c1_respack : c0_respack;
    assign beat          = in_resp && bus_respcyc && owner_respack;
    assign last_beat     = beat && (beat_cnt == CW'(BEATS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; the first beat is consumed in WAIT itself.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (c0_reqcyc || c1_reqcyc) state_nxt = REQ;
            REQ:  if (bus_reqack) state_nxt = WAIT;
            WAIT: begin
                if (last_beat)        state_nxt = IDLE;
                else if (bus_respcyc) state_nxt = RESP;
            end
            RESP: if (last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant capture, registered request and beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= 1'b0;
            bus_req    <= '0;
            bus_reqtag <= '0;
            beat_cnt   <= '0;
        end else begin
            if (state == IDLE && (c0_reqcyc || c1_reqcyc)) begin
                owner      <= winner;
                bus_req    <= winner ? c1_req : c0_req;
                bus_reqtag <= winner ? c1_reqtag : c0_reqtag;
            end
            if (last_beat)
                beat_cnt <= '0;
            else if (beat)
                beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Output decode: handshakes are steered to the owner only; stray
    // responses outside WAIT/RESP are neither forwarded nor acknowledged.
    always_comb begin
        bus_reqcyc  = (state == REQ);
        busy        = (state != IDLE);
        c0_reqack   = (state == REQ) && !owner && bus_reqack;
        c1_reqack   = (state == REQ) &&  owner && bus_reqack;
        c0_respcyc  = in_resp && !owner && bus_respcyc;
        c1_respcyc  = in_resp &&  owner && bus_respcyc;
        bus_respack = in_resp && owner_respack;
        c0_resp     = bus_resp;
        c1_resp     = bus_resp;
        c0_resptag  = bus_resptag;
        c1_resptag  = bus_resptag;
    end

endmodule
